// File: rtl/uart_tx_periph_if.sv
// Register bus between the address decoder and the UART transmitter.
// The CPU side drives strobes, address and write data.
// The peripheral side returns combinational read data.
interface uart_tx_periph_if;
    logic        wen;
    logic        ren;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output wen, output ren, output addr, output wdata, input rdata);
    modport slave  (input wen, input ren, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: byte FIFO, runtime baud divisor, 8N1 serialiser.
// Register map: 0x0 DATA (push), 0x4 STATUS, 0x8 DIVISOR, 0xC reserved.
module uart_tx_periph #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_periph_if.slave  bus,
    output logic             tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   divisor_q;

    // Serialiser
    state_t        state_q;
    logic [15:0]   cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          tx_q;

    logic [1:0]    sel;
    logic          wr_data, wr_status, wr_div;
    logic          full, empty, pop, push_ok, drop;
    logic [31:0]   rdata_c;
    logic          unused_bits;

    assign sel       = bus.addr[3:2];
    assign wr_data   = bus.wen && !reset && (sel == 2'd0);
    assign wr_status = bus.wen && !reset && (sel == 2'd1);
    assign wr_div    = bus.wen && !reset && (sel == 2'd2);

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    // The head leaves the FIFO only on the single IDLE cycle between frames.
    assign pop     = (state_q == IDLE) && !empty;
    // A push onto a full FIFO is fine when the head leaves on the same edge.
    assign push_ok = wr_data && (!full || pop);
    assign drop    = wr_data && full && !pop;

    // Read strobe, ignored address bits and upper write bits carry no function.
    assign unused_bits = ^{bus.ren, bus.addr[1:0], bus.wdata[31:16]};

    // Next FIFO occupancy and sticky overflow (a drop beats a clear)
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q;
        if (wr_status) ovf_d = 1'b0;
        if (drop)      ovf_d = 1'b1;
    end

    // FIFO storage write; no reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= bus.wdata[7:0];
    end

    // FIFO pointers, count, overflow flag and divisor register
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            divisor_q <= 16'(CLKS_PER_BIT);
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (wr_div) divisor_q <= (bus.wdata[15:0] < 16'd4) ? 16'd4 : bus.wdata[15:0];
        end
    end

    // Frame sequencer; divisor is sampled only when a bit period is loaded
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem[rd_ptr_q];
                        cnt_q   <= divisor_q - 16'd1;
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (cnt_q == 16'd0) begin
                        state_q   <= DATA;
                        bit_idx_q <= 3'd0;
                        cnt_q     <= divisor_q - 16'd1;
                        tx_q      <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                DATA: begin
                    if (cnt_q == 16'd0) begin
                        cnt_q <= divisor_q - 16'd1;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (cnt_q == 16'd0) state_q <= IDLE;
                    else                cnt_q   <= cnt_q - 16'd1;
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // Zero-latency register read mux
    always_comb begin
        rdata_c = '0;
        case (sel)
            2'd1: begin
                rdata_c[0]       = (state_q != IDLE);
                rdata_c[1]       = full;
                rdata_c[2]       = empty;
                rdata_c[3]       = ovf_q;
                rdata_c[4 +: CW] = count_q;
            end
            2'd2:    rdata_c[15:0] = divisor_q;
            default: rdata_c = '0;
        endcase
    end

    assign bus.rdata = rdata_c;
    assign tx        = tx_q;
endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: queue-based frame model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_uart_tx_periph;
    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    uart_tx_periph_if bus_if ();

    uart_tx_periph #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [63:0] tx_hist = '0;

    // Behavioural model: byte queue plus the list of line levels still to send
    logic [7:0] q[$];
    bit         bits[$];
    int         rem    = 0;
    bit         m_busy = 0;
    bit         m_ovf  = 0;
    int         m_div  = CPB;
    bit         m_tx   = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit         pop;
        int         old_div;
        logic [7:0] head;
        if (reset) begin
            q.delete(); bits.delete();
            rem = 0; m_busy = 0; m_ovf = 0; m_div = CPB; m_tx = 1;
            return;
        end
        pop     = !m_busy && (q.size() != 0);
        old_div = m_div;
        head    = 8'h00;
        if (pop) head = q.pop_front();
        if (m_busy) begin
            rem--;
            if (rem == 0) begin
                void'(bits.pop_front());
                if (bits.size() == 0) begin
                    m_busy = 0; m_tx = 1;
                end else begin
                    rem = old_div; m_tx = bits[0];
                end
            end
        end else if (pop) begin
            bits.delete();
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(head[i]);
            bits.push_back(1'b1);
            rem = old_div; m_tx = 0; m_busy = 1;
        end
        if (bus_if.wen) begin
            case (bus_if.addr[3:2])
                2'd0: if (q.size() < DEPTH) q.push_back(bus_if.wdata[7:0]); else m_ovf = 1;
                2'd1: m_ovf = 0;
                2'd2: m_div = (bus_if.wdata[15:0] < 16'd4) ? 4 : int'(bus_if.wdata[15:0]);
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] exp_rdata(input logic [3:0] a);
        logic [31:0] r;
        int n;
        r = '0;
        n = q.size();
        case (a[3:2])
            2'd1: begin
                r[0] = m_busy; r[1] = (n == DEPTH); r[2] = (n == 0); r[3] = m_ovf;
                r[8:4] = 5'(n);
            end
            2'd2: r[15:0] = 16'(m_div);
            default: ;
        endcase
        return r;
    endfunction

    // The single per-cycle compare against the model
    task automatic compare();
        chk("tx_line", {31'b0, tx}, {31'b0, m_tx});
        chk("rdata", bus_if.rdata, exp_rdata(bus_if.addr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
        cyc++;
        tx_hist = {tx_hist[62:0], tx};
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus_if.addr = a; bus_if.wdata = d; bus_if.wen = 1'b1;
        tick();
        bus_if.wen = 1'b0; bus_if.addr = 4'h4;
    endtask

    task automatic do_reset();
        reset = 1'b1; bus_if.wen = 1'b0; bus_if.addr = 4'h4;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        bus_if.addr = 4'h4;
        for (int i = 0; i < budget; i++) begin
            if (bus_if.rdata == 32'h4) break;
            tick();
        end
        chk(name, bus_if.rdata, 32'h4);
    endtask

    task automatic find_low(output int t, input int budget);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            if (tx === 1'b0) begin
                t = cyc;
                return;
            end
            tick();
        end
    endtask

    initial begin
        logic [9:0] pat;
        int s1, s2;
        reset = 1'b1;
        bus_if.wen = 1'b0; bus_if.ren = 1'b0; bus_if.addr = 4'h4; bus_if.wdata = '0;

        // Reset state
        do_reset();
        chk("rst_status", bus_if.rdata, 32'h4);
        chk("rst_tx", {31'b0, tx}, 32'h1);
        bus_if.addr = 4'h8; tick();
        chk("rst_div", bus_if.rdata, 32'(CPB));

        // Single byte 0x55 at divisor 4
        do_reset();
        wr(4'h8, 32'h4);
        wr(4'h0, 32'h55);
        pat = 10'b1010101010;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("b55_tx", {31'b0, tx}, {31'b0, pat[i/4]});
            chk("b55_busy", {31'b0, bus_if.rdata[0]}, 32'h1);
        end
        tick();
        chk("b55_done", bus_if.rdata, 32'h4);

        // Overflow with slow divisor
        do_reset();
        wr(4'h8, 32'd100);
        for (int i = 0; i < 6; i++) wr(4'h0, 32'(8'h30 + i));
        #1 chk("ovf_status", bus_if.rdata, 32'h4B);
        wr(4'h4, $urandom);
        #1 chk("ovf_clear", bus_if.rdata, 32'h43);
        drain("ovf_drain", 6000);

        // Back-to-back frames are 41 cycles apart
        do_reset();
        wr(4'h8, 32'h4);
        wr(4'h0, 32'hA3);
        wr(4'h0, 32'h0F);
        find_low(s1, 10);
        repeat (40) tick();
        find_low(s2, 10);
        chk("b2b_spacing", 32'(s2 - s1), 32'd41);
        drain("b2b_drain", 100);

        // Divisor clamp and mid-bit divisor change
        do_reset();
        wr(4'h8, 32'h2);
        bus_if.addr = 4'h8; tick();
        chk("div_clamp", bus_if.rdata, 32'h4);
        wr(4'h0, 32'h01);
        tick(); tick();
        wr(4'h8, 32'h8);
        repeat (13) tick();
        chk("div_change", {16'b0, tx_hist[15:0]}, 32'h0FF0);
        drain("div_drain", 200);

        // Reset during data bit 3
        do_reset();
        wr(4'h8, 32'h4);
        wr(4'h0, 32'h00);
        repeat (18) tick();
        chk("mid_busy", {31'b0, bus_if.rdata[0]}, 32'h1);
        reset = 1'b1;
        tick();
        chk("mid_tx", {31'b0, tx}, 32'h1);
        chk("mid_status", bus_if.rdata, 32'h4);
        reset = 1'b0;
        bus_if.addr = 4'h8; tick();
        chk("mid_div", bus_if.rdata, 32'(CPB));

        // Push on full FIFO coinciding with the IDLE pop
        do_reset();
        wr(4'h8, 32'h4);
        for (int i = 0; i < 5; i++) wr(4'h0, 32'(8'h11 * (i + 1)));
        repeat (37) tick();
        wr(4'h0, 32'h66);
        #1 chk("full_pushpop", bus_if.rdata, 32'h43);
        drain("full_drain", 400);

        // Random traffic
        do_reset();
        for (int i = 0; i < 25000; i++) begin
            bus_if.ren   = 1'($urandom_range(0, 1));
            reset        = ($urandom_range(0, 2999) == 0);
            bus_if.wen   = ($urandom_range(0, 7) == 0);
            bus_if.addr  = 4'($urandom_range(0, 15));
            bus_if.wdata = $urandom;
            if (bus_if.addr[3:2] == 2'd2) bus_if.wdata[15:0] = 16'($urandom_range(0, 9));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, reset value of the baud divisor (legal range 4..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, transmit FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port wen  input  1  write strobe, driven by the address decoder's peripheral write-enable for this region.
REQ-006 SHALL have port ren  input  1  read strobe; has no side effects and is not required for rdata.
REQ-007 SHALL have port addr  input  4  byte-address low bits; addr[3:2] selects the register, addr[1:0] is ignored.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  read data, returned to the CPU through the decoder-selected read mux.
REQ-010 SHALL have port tx  output  1  serial line, idle high.

Function
REQ-011 SHALL provide the register map: 0x0 DATA (write-only, reads 0); 0x4 STATUS; 0x8 DIVISOR[15:0]; 0xC reserved (reads 0, writes ignored).
REQ-012 SHALL drive rdata combinationally from addr and current state, with zero cycles of latency and unused bits as 0.
REQ-013 SHALL define STATUS as: bit0 busy (FSM not IDLE); bit1 full; bit2 empty; bit3 overflow (sticky); bits[8:4] FIFO count.
REQ-014 SHALL treat a wen to DATA as a push of wdata[7:0] when the FIFO is not full.
REQ-015 SHALL drop a DATA write that arrives while the FIFO is full with no pop in the same cycle, and SHALL set overflow.
REQ-016 SHALL accept a push that coincides with a pop on a full FIFO, leaving the count unchanged.
REQ-017 SHALL clear overflow on any wen to STATUS, regardless of wdata; if a drop occurs in the same cycle, set takes priority.
REQ-018 SHALL load DIVISOR from wdata[15:0] on a wen to 0x8, storing 4 when the written value is below 4.
REQ-019 SHALL implement the FSM states IDLE, START, DATA, and STOP.
REQ-020 In IDLE, SHALL hold tx=1; when the FIFO is non-empty, SHALL pop the head into an 8-bit shift register, load the bit counter with DIVISOR-1, and enter START on the next edge.
REQ-021 In START, SHALL hold tx=0 for DIVISOR cycles, then enter DATA with bit index 0.
REQ-022 In DATA, SHALL drive shift[0] (LSB first) for DIVISOR cycles per bit, then shift right; after bit index 7, SHALL enter STOP.
REQ-023 In STOP, SHALL hold tx=1 for DIVISOR cycles, then return to IDLE.
REQ-024 SHALL spend exactly one cycle in IDLE between back-to-back frames, giving a frame period of 10*DIVISOR+1 clocks.
REQ-025 SHALL sample a DIVISOR change only when a bit period is loaded; a bit already in progress SHALL keep its length.
REQ-026 SHALL implement FIFO pointers as modulo FIFO_DEPTH with a separate count of width log2(FIFO_DEPTH)+1, with no wrap aliasing between full and empty.
REQ-027 SHALL ensure a DATA write cannot alter the byte currently in the shift register.

Reset
REQ-028 While reset is high at a clock edge, SHALL clear the FIFO, set state to IDLE, tx=1, overflow=0, and DIVISOR=CLKS_PER_BIT.
REQ-029 SHALL let reset asserted mid-frame abort the frame, driving tx=1 from the following edge; the aborted byte and any queued bytes are lost.
REQ-030 SHALL ignore wen while reset is high.
REQ-031 After reset, SHALL read STATUS as 0x004 (empty=1, all other bits 0).

Verification
REQ-032 Single byte: DIVISOR=4, write DATA=0x55 -> tx pattern over 40 cycles is 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; busy=1 throughout, then STATUS=0x004.
REQ-033 Overflow: DIVISOR=100, write 6 bytes back-to-back -> first byte is popped; 4 bytes queued, 1 dropped; STATUS reads full=1, overflow=1, count=4; write STATUS -> overflow=0.
REQ-034 Back-to-back: DIVISOR=4, write 0xA3 then 0x0F -> second start bit falls 41 cycles after the first start bit; both bytes serialised correctly.
REQ-035 Divisor clamp/update: write DIVISOR=2 -> reads 4; write DIVISOR=8 mid-bit -> current bit keeps the old length and the next bit lasts 8 cycles.
REQ-036 Reset mid-frame: assert reset during DATA bit 3 of 0x00 -> tx=1 from the next cycle, STATUS=0x004, DIVISOR=CLKS_PER_BIT.
REQ-037 Simultaneous push and pop at full: FIFO full, push timed to the IDLE pop cycle -> count stays FIFO_DEPTH, overflow=0, and all bytes are emitted in order.
